hazard_unit_mc: RTL and testbench
=================================

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter REG_AW, default 5: register-address width.
REQ-003 SHALL have parameter MD_LATENCY, default 4: multiply/divide busy cycles, legal range 1..15.
REQ-004 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have inputs RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, each REG_AW bits: source and destination register addresses per stage.
REQ-008 SHALL have 1-bit inputs BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW: pipeline control.
REQ-009 SHALL have 1-bit inputs MdStartD, MdStartE, MdUseD: mult/div op in D, mult/div op in E, HI/LO reader in D.
REQ-010 SHALL have 1-bit inputs MemAccessM, MemReadyM: M-stage load/store pending; data memory ready.
REQ-011 SHALL have 1-bit outputs StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MdBusy.
REQ-012 SHALL have 2-bit outputs ForwardAE and ForwardBE: 00 = register file, 01 = W result, 10 = M result.
REQ-013 SHALL have output StallCount, CNT_W bits: saturating count of cycles with StallF high.

Function
REQ-014 SHALL drive ForwardAE = 10 when RsE != 0 && RsE == WriteRegM && RegWriteM; else 01 when RsE != 0 && RsE == WriteRegW && RegWriteW; else 00.
REQ-015 SHALL drive ForwardBE by the same rule as REQ-014, using RtE in place of RsE.
REQ-016 SHALL drive ForwardAD = (RsD != 0 && RsD == WriteRegM && RegWriteM) and ForwardBD likewise using RtD; all forwarding outputs are combinational.
REQ-017 SHALL assert lwstall = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE).
REQ-018 SHALL assert branchstall = BranchD && ((RegWriteE && WriteRegE != 0 && WriteRegE in {RsD, RtD}) || (MemtoRegM && WriteRegM != 0 && WriteRegM in {RsD, RtD})).
REQ-019 SHALL assert mdstall = MdBusy && (MdUseD || MdStartD).
REQ-020 SHALL assert memstall = MemAccessM && !MemReadyM.
REQ-021 SHALL, when memstall is high, assert StallF, StallD, StallE, StallM and FlushW and hold FlushE = 0; memstall has highest priority.
REQ-022 SHALL, when memstall is low and any of lwstall, branchstall or mdstall is high, assert StallF, StallD and FlushE, with StallE = StallM = FlushW = 0.
REQ-023 SHALL, with no stall condition, drive all stall and flush outputs to 0.
REQ-024 SHALL implement a mult/div FSM with states IDLE and BUSY, and a down-counter mdcnt of 4 bits; MdBusy = (state == BUSY).
REQ-025 SHALL transition IDLE to BUSY on a rising edge where MdStartE && !StallE, loading mdcnt = MD_LATENCY.
REQ-026 SHALL, in BUSY, decrement mdcnt every cycle regardless of stalls, and return to IDLE on the edge where mdcnt == 1.
REQ-027 SHALL ignore MdStartE while in BUSY; REQ-019 prevents a legal second issue.
REQ-028 SHALL keep a MdStartE held in E by StallE from starting the FSM until the cycle StallE drops, so each op starts exactly once.
REQ-029 SHALL increment StallCount on each edge where StallF is high, and hold StallCount at 2^CNT_W-1 (no wrap).

Reset
REQ-030 SHALL, on reset high at an edge, set state = IDLE, mdcnt = 0 and StallCount = 0; reset overrides a simultaneous start.
REQ-031 SHALL, while reset is high, drive MdBusy = 0; combinational outputs follow their inputs.
REQ-032 SHALL abandon any in-flight BUSY count on reset mid-operation, with no residual stall.

Verification
REQ-033 SHALL cover forwarding precedence: RsE = 5, WriteRegM = 5, WriteRegW = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10; then RsE = 0 -> ForwardAE = 00.
REQ-034 SHALL cover load-use: MemtoRegE = 1, RtE = 8, RsD = 8 -> StallF = StallD = FlushE = 1 for one cycle; with RtE = 0 -> no stall.
REQ-035 SHALL cover mult/div: MdStartE pulse, MD_LATENCY = 4 -> MdBusy high for exactly 4 cycles; MdUseD held high -> StallF high those 4 cycles, StallCount = 4.
REQ-036 SHALL cover memory wait: MemAccessM = 1, MemReadyM = 0 for 3 cycles, with lwstall also true -> StallF, StallD, StallE, StallM and FlushW = 1, FlushE = 0 for 3 cycles.
REQ-037 SHALL cover reset mid-op: reset at the 2nd BUSY cycle -> MdBusy = 0 and StallCount = 0 on the next cycle.
REQ-038 SHALL cover counter saturation: with CNT_W = 3, 10 consecutive stall cycles -> StallCount = 7 and it stays 7.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: combinational forwarding/stall/flush, a mult/div busy FSM and a stall counter.
// Zero-latency outputs except MdBusy/StallCount; a memory wait freezes F..M and bubbles W.
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              BranchD,
  input  logic              MemtoRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegM,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MdStartD,
  input  logic              MdStartE,
  input  logic              MdUseD,
  input  logic              MemAccessM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MdBusy,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic {IDLE, BUSY} mdState_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY);

  mdState_t   state, stateNext;
  logic [3:0] mdcnt, mdcntNext;
  logic       lwstall, branchstall, mdstall, memstall;

  assign ForwardAE = (RsE != '0 && RsE == WriteRegM && RegWriteM) ? 2'b10 :
                     (RsE != '0 && RsE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
  assign ForwardBE = (RtE != '0 && RtE == WriteRegM && RegWriteM) ? 2'b10 :
                     (RtE != '0 && RtE == WriteRegW && RegWriteW) ? 2'b01 : 2'b00;
  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  // Gated by reset so a reset landing mid-operation leaves no stall behind.
  assign MdBusy = (state == BUSY) && !reset;

  assign lwstall     = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
  assign branchstall = BranchD &&
                       ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                        (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
  assign mdstall     = MdBusy && (MdUseD || MdStartD);
  assign memstall    = MemAccessM && !MemReadyM;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwstall || branchstall || mdstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    mdcntNext = mdcnt;
    if (state == IDLE) begin
      // An op frozen in E by StallE starts only once it is released.
      if (MdStartE && !StallE) begin
        stateNext = BUSY;
        mdcntNext = MD_INIT;
      end
    end else begin
      mdcntNext = mdcnt - 4'd1;
      if (mdcnt == 4'd1) stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mdcnt <= 4'd0;
    end else begin
      state <= stateNext;
      mdcnt <= mdcntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && StallCount != {CNT_W{1'b1}}) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed vectors push expected outputs, a negedge monitor compares.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
  logic       MdStartD, MdStartE, MdUseD, MemAccessM, MemReadyM;

  logic       StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic       sStallF, sStallD, sStallE, sStallM, sFlushE, sFlushW, sForwardAD, sForwardBD, sMdBusy;
  logic [1:0] sForwardAE, sForwardBE;
  logic [2:0] satCount;

  always #5 clk = ~clk;

  hazard_unit_mc dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .BranchD(BranchD), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MdUseD(MdUseD),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount)
  );

  hazard_unit_mc #(.CNT_W(3)) dutSat (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .BranchD(BranchD), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MdUseD(MdUseD),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallM(sStallM),
    .FlushE(sFlushE), .FlushW(sFlushW), .ForwardAD(sForwardAD), .ForwardBD(sForwardBD),
    .MdBusy(sMdBusy), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE), .StallCount(satCount)
  );

  // {StallF,StallD,StallE,StallM,FlushE,FlushW, ForwardAD,ForwardBD, MdBusy, ForwardAE, ForwardBE, StallCount, satCount}
  logic [31:0] act;
  assign act = {StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
                MdBusy, ForwardAE, ForwardBE, StallCount, satCount};

  logic [31:0] expQ[$];
  string       nameQ[$];
  int          passCnt = 0;
  int          totalCnt = 0;
  logic [15:0] expCnt;
  logic [2:0]  expSat;

  localparam logic [5:0] N = 6'b000000;  // no stall
  localparam logic [5:0] L = 6'b110010;  // StallF, StallD, FlushE
  localparam logic [5:0] M = 6'b111101;  // StallF..StallM, FlushW

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      totalCnt++;
      if (act === e) passCnt++;
      else $display("FAIL %s: got %h expected %h", n, act, e);
    end
  end

  // Push the expected outputs for the current input set, then advance one cycle.
  task automatic cyc(input string nm, input logic [5:0] st, input logic [1:0] fd,
                     input logic busy, input logic [1:0] ae, input logic [1:0] be);
    expQ.push_back({st, fd, busy, ae, be, expCnt, expSat});
    nameQ.push_back(nm);
    @(posedge clk);
    if (reset) begin
      expCnt = '0;
      expSat = '0;
    end else if (st[5]) begin
      expCnt++;
      if (expSat != 3'd7) expSat++;
    end
    #1;
  endtask

  task automatic clr();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW} = '0;
    {MdStartD, MdStartE, MdUseD, MemAccessM} = '0;
    MemReadyM = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passCnt, totalCnt);
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expCnt = '0;
    expSat = '0;

    cyc("reset_state", N, 2'b00, 1'b0, 2'b00, 2'b00);

    // Forwarding precedence and r0 exclusion
    RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    cyc("fwd_m_prec", N, 2'b00, 1'b0, 2'b10, 2'b00);
    RegWriteM = 0;
    cyc("fwd_w", N, 2'b00, 1'b0, 2'b01, 2'b00);
    RegWriteM = 1; RsE = 0;
    cyc("fwd_r0", N, 2'b00, 1'b0, 2'b00, 2'b00);
    RtE = 5; RsD = 5; RtD = 3;
    cyc("fwd_be_ad", N, 2'b10, 1'b0, 2'b00, 2'b10);
    clr();

    // Load-use
    MemtoRegE = 1; RtE = 8; RsD = 8;
    cyc("lw_stall", L, 2'b00, 1'b0, 2'b00, 2'b00);
    MemtoRegE = 0;
    cyc("lw_release", N, 2'b00, 1'b0, 2'b00, 2'b00);
    MemtoRegE = 1; RtE = 0; RsD = 0;
    cyc("lw_r0", N, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();

    // Branch hazards from E and from a load in M
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    cyc("br_e", L, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();
    BranchD = 1; RtD = 4; MemtoRegM = 1; WriteRegM = 4;
    cyc("br_m", L, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();

    reset = 1'b1;
    cyc("rst_cycle", N, 2'b00, 1'b0, 2'b00, 2'b00);
    reset = 1'b0;

    // Mult/div occupancy with a dependent HI/LO reader waiting in D
    MdStartE = 1;
    cyc("md_issue", N, 2'b00, 1'b0, 2'b00, 2'b00);
    MdStartE = 0; MdUseD = 1;
    for (int i = 0; i < 4; i++) cyc("md_busy", L, 2'b00, 1'b1, 2'b00, 2'b00);
    cyc("md_done", N, 2'b00, 1'b0, 2'b00, 2'b00);
    if (StallCount !== 16'd4) $display("FAIL md_count: StallCount %0d expected 4", StallCount);
    clr();

    // Memory wait dominates a simultaneous load-use
    MemAccessM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 8; RsD = 8;
    for (int i = 0; i < 3; i++) cyc("mem_wait", M, 2'b00, 1'b0, 2'b00, 2'b00);
    MemReadyM = 1;
    cyc("mem_done_lw", L, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();

    // A start frozen in E by a memory wait fires once, after release
    MemAccessM = 1; MemReadyM = 0; MdStartE = 1;
    for (int i = 0; i < 2; i++) cyc("md_held", M, 2'b00, 1'b0, 2'b00, 2'b00);
    MemReadyM = 1;
    cyc("md_release", N, 2'b00, 1'b0, 2'b00, 2'b00);
    MdStartE = 0;
    for (int i = 0; i < 4; i++) cyc("md_once", N, 2'b00, 1'b1, 2'b00, 2'b00);
    cyc("md_once_end", N, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();

    // Reset during the second BUSY cycle
    MdStartE = 1;
    cyc("rmo_issue", N, 2'b00, 1'b0, 2'b00, 2'b00);
    MdStartE = 0; MdUseD = 1;
    cyc("rmo_busy1", L, 2'b00, 1'b1, 2'b00, 2'b00);
    reset = 1'b1;
    cyc("rmo_reset", N, 2'b00, 1'b0, 2'b00, 2'b00);
    reset = 1'b0;
    cyc("rmo_after", N, 2'b00, 1'b0, 2'b00, 2'b00);
    if (MdBusy !== 1'b0 || StallCount !== 16'd0)
      $display("FAIL rmo_state: MdBusy %b StallCount %0d", MdBusy, StallCount);
    clr();

    // 3-bit counter saturates at 7 while the 16-bit one keeps counting
    MemtoRegE = 1; RtE = 8; RsD = 8;
    for (int i = 0; i < 10; i++) cyc("sat_run", L, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();
    cyc("sat_hold", N, 2'b00, 1'b0, 2'b00, 2'b00);
    MemtoRegE = 1; RtE = 8; RtD = 8;
    cyc("sat_more", L, 2'b00, 1'b0, 2'b00, 2'b00);
    clr();
    cyc("sat_final", N, 2'b00, 1'b0, 2'b00, 2'b00);
    if (satCount !== 3'd7) $display("FAIL sat_value: satCount %0d expected 7", satCount);
    if (StallCount !== 16'd11) $display("FAIL wide_value: StallCount %0d expected 11", StallCount);
    if (passCnt !== totalCnt) $display("FAIL summary: %0d of %0d monitor checks failed", totalCnt - passCnt, totalCnt);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
